// File: rtl/raster_timing_pkg.sv
// Shared raster timing types, the window-compare helper, and the default
// timing constants for the Space Race board.
package raster_timing_pkg;

  localparam int unsigned WIN_W = 16;

  // Half-open window [beg, fin); beg == fin means the window is never active
  typedef struct packed {
    logic [WIN_W-1:0] beg;
    logic [WIN_W-1:0] fin;
  } raster_win_t;

  localparam int unsigned DEF_H_TOTAL     = 454;
  localparam int unsigned DEF_V_TOTAL     = 262;
  localparam int unsigned DEF_H_BLANK_BEG = 374;
  localparam int unsigned DEF_H_SYNC_BEG  = 400;
  localparam int unsigned DEF_H_SYNC_END  = 432;
  localparam int unsigned DEF_V_BLANK_BEG = 224;
  localparam int unsigned DEF_V_SYNC_BEG  = 236;
  localparam int unsigned DEF_V_SYNC_END  = 240;

  function automatic logic in_window(input logic [WIN_W-1:0] cnt, input raster_win_t win);
    return (cnt >= win.beg) && (cnt < win.fin);
  endfunction

endpackage

// File: rtl/raster_timing_counter_mod_counter.sv
// Modulo-MOD counter with clock enable and synchronous clear; tc_c flags the
// terminal count so wrap is a compare, not a width overflow.
module mod_counter #(
  parameter int unsigned MOD = 2,
  parameter int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  assign tc_c = (cnt == W'(MOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ce) begin
      if (tc_c) cnt <= '0;
      else      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/raster_timing_counter.sv
// Horizontal/vertical raster counter with blank/sync decodes and a field
// toggle; decodes are pure compares on the count registers.
module raster_timing_counter
  import raster_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned H_BLANK_BEG = DEF_H_BLANK_BEG,
  parameter int unsigned H_SYNC_BEG  = DEF_H_SYNC_BEG,
  parameter int unsigned H_SYNC_END  = DEF_H_SYNC_END,
  parameter int unsigned V_BLANK_BEG = DEF_V_BLANK_BEG,
  parameter int unsigned V_SYNC_BEG  = DEF_V_SYNC_BEG,
  parameter int unsigned V_SYNC_END  = DEF_V_SYNC_END,
  parameter int unsigned H_W         = $clog2(H_TOTAL),
  parameter int unsigned V_W         = $clog2(V_TOTAL)
) (
  input  logic           CLK_DRV,
  input  logic           RESET_N,
  input  logic           CE,
  input  logic           SYNC_CLR,
  output logic [H_W-1:0] HCNT,
  output logic [V_W-1:0] VCNT,
  output logic           HRESET,
  output logic           VRESET,
  output logic           VRESET_N,
  output logic           HBLANK,
  output logic           VBLANK,
  output logic           HSYNC_N,
  output logic           VSYNC_N,
  output logic           CSYNC_N,
  output logic           FIELD
);

  localparam raster_win_t H_BLANK_WIN = '{beg: WIN_W'(H_BLANK_BEG), fin: WIN_W'(H_TOTAL)};
  localparam raster_win_t H_SYNC_WIN  = '{beg: WIN_W'(H_SYNC_BEG),  fin: WIN_W'(H_SYNC_END)};
  localparam raster_win_t V_BLANK_WIN = '{beg: WIN_W'(V_BLANK_BEG), fin: WIN_W'(V_TOTAL)};
  localparam raster_win_t V_SYNC_WIN  = '{beg: WIN_W'(V_SYNC_BEG),  fin: WIN_W'(V_SYNC_END)};

  // Reject parameter sets whose windows would wrap past the line/frame end
  if (H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_total
    $error("raster_timing_counter: H_TOTAL and V_TOTAL must be >= 2");
  end
  if (H_BLANK_BEG > H_TOTAL || H_SYNC_BEG > H_SYNC_END || H_SYNC_END > H_TOTAL) begin : g_bad_hwin
    $error("raster_timing_counter: horizontal window out of range");
  end
  if (V_BLANK_BEG > V_TOTAL || V_SYNC_BEG > V_SYNC_END || V_SYNC_END > V_TOTAL) begin : g_bad_vwin
    $error("raster_timing_counter: vertical window out of range");
  end

  logic h_tc;
  logic v_tc;
  logic v_ce;

  assign v_ce = CE & h_tc;

  mod_counter #(.MOD(H_TOTAL), .W(H_W)) u_hcnt (
    .clk   (CLK_DRV),
    .rst_n (RESET_N),
    .ce    (CE),
    .clr   (SYNC_CLR),
    .cnt   (HCNT),
    .tc_c  (h_tc)
  );

  mod_counter #(.MOD(V_TOTAL), .W(V_W)) u_vcnt (
    .clk   (CLK_DRV),
    .rst_n (RESET_N),
    .ce    (v_ce),
    .clr   (SYNC_CLR),
    .cnt   (VCNT),
    .tc_c  (v_tc)
  );

  // Field flips on the frame-wrap edge; genlock restart leaves it alone
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      FIELD <= 1'b0;
    end else if (!SYNC_CLR && v_ce && v_tc) begin
      FIELD <= ~FIELD;
    end
  end

  assign HRESET   = h_tc;
  assign VRESET   = v_tc;
  assign VRESET_N = ~v_tc;
  assign HBLANK   = in_window(WIN_W'(HCNT), H_BLANK_WIN);
  assign VBLANK   = in_window(WIN_W'(VCNT), V_BLANK_WIN);
  assign HSYNC_N  = ~in_window(WIN_W'(HCNT), H_SYNC_WIN);
  assign VSYNC_N  = ~in_window(WIN_W'(VCNT), V_SYNC_WIN);
  assign CSYNC_N  = HSYNC_N & VSYNC_N;

endmodule

// File: tb/tb_raster_timing_counter.sv
// Scoreboarded bench for raster_timing_counter on a small 8x5 raster, using a
// pixel-index reference model.
module tb_raster_timing_counter;

  localparam int unsigned HT = 8;
  localparam int unsigned VT = 5;

  logic       CLK_DRV = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CE = 1'b0;
  logic       SYNC_CLR = 1'b0;
  logic [2:0] HCNT;
  logic [2:0] VCNT;
  logic HRESET, VRESET, VRESET_N, HBLANK, VBLANK, HSYNC_N, VSYNC_N, CSYNC_N, FIELD;

  raster_timing_counter #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_BLANK_BEG(6), .H_SYNC_BEG(6), .H_SYNC_END(7),
    .V_BLANK_BEG(4), .V_SYNC_BEG(4), .V_SYNC_END(5)
  ) dut (
    .CLK_DRV(CLK_DRV), .RESET_N(RESET_N), .CE(CE), .SYNC_CLR(SYNC_CLR),
    .HCNT(HCNT), .VCNT(VCNT), .HRESET(HRESET), .VRESET(VRESET), .VRESET_N(VRESET_N),
    .HBLANK(HBLANK), .VBLANK(VBLANK), .HSYNC_N(HSYNC_N), .VSYNC_N(VSYNC_N),
    .CSYNC_N(CSYNC_N), .FIELD(FIELD)
  );

  always #5 CLK_DRV = ~CLK_DRV;

  typedef struct packed {
    logic [2:0] h;
    logic [2:0] v;
    logic hres, vres, vres_n, hb, vb, hs_n, vs_n, cs_n, field;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pix = 0;          // pixel index within the current frame
  logic field_m = 1'b0;

  // Reference: position derived from a linear pixel index within the frame
  function automatic obs_t model(input int p, input logic f);
    obs_t o;
    int h, v;
    h = p % HT;
    v = p / HT;
    o.h      = 3'(h);
    o.v      = 3'(v);
    o.hres   = (h == HT - 1);
    o.vres   = (v == VT - 1);
    o.vres_n = !(v == VT - 1);
    o.hb     = (h >= 6);
    o.vb     = (v >= 4);
    o.hs_n   = !(h >= 6 && h < 7);
    o.vs_n   = !(v >= 4 && v < 5);
    o.cs_n   = o.hs_n && o.vs_n;
    o.field  = f;
    return o;
  endfunction

  function automatic obs_t observe();
    return '{HCNT, VCNT, HRESET, VRESET, VRESET_N, HBLANK, VBLANK, HSYNC_N, VSYNC_N, CSYNC_N, FIELD};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
               name, got.h, got.v, got[8:0], exp.h, exp.v, exp[8:0]);
    end
  endtask

  // Drive one edge's inputs and queue the state expected after that edge
  task automatic step(input logic ce, input logic clr);
    @(negedge CLK_DRV);
    CE = ce;
    SYNC_CLR = clr;
    if (clr) begin
      pix = 0;
    end else if (ce) begin
      pix++;
      if (pix == HT * VT) begin
        pix = 0;
        field_m = ~field_m;
      end
    end
    exp_q.push_back(model(pix, field_m));
  endtask

  always @(posedge CLK_DRV) begin
    #1;
    if (RESET_N && exp_q.size() > 0) check("cycle", observe(), exp_q.pop_front());
  end

  initial begin
    #2;
    check("reset", observe(), model(0, 1'b0));
    @(negedge CLK_DRV);
    RESET_N = 1'b1;

    // Free run through one full frame
    repeat (HT * VT) step(1'b1, 1'b0);
    @(posedge CLK_DRV);
    #2;
    tests++;
    if (FIELD !== 1'b1) begin
      fails++;
      $display("FAIL field_after_frame: got %b expected 1", FIELD);
    end

    // Half-rate enable
    for (int i = 0; i < 40; i++) step(i[0] == 1'b0, 1'b0);

    // Genlock restart at h=5 v=3
    step(1'b0, 1'b1);
    repeat (3 * HT + 5) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // Async reset mid-cycle at h=3 v=2
    step(1'b0, 1'b1);
    repeat (2 * HT + 3) step(1'b1, 1'b0);
    @(posedge CLK_DRV);
    #3;
    RESET_N = 1'b0;
    #1;
    check("async_reset", observe(), model(0, 1'b0));
    pix = 0;
    field_m = 1'b0;
    @(negedge CLK_DRV);
    RESET_N = 1'b1;
    CE = 1'b0;
    SYNC_CLR = 1'b0;
    step(1'b1, 1'b0);

    // Randomized enable and restart
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);

    step(1'b0, 1'b0);
    repeat (3) @(posedge CLK_DRV);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
